db25_input_filter: RTL and testbench



---
 rtl/db25_input_filter_if.sv | 14 +
 rtl/db25_input_filter.sv | 105 ++++++++++
 tb/tb_db25_input_filter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db25_input_filter_if.sv
// Local hostmot2 register bus between the bus master and db25_input_filter.
// Single-cycle strobes, registered read data, no wait states.
interface db25_input_filter_if #(
   parameter int BusWidth = 32
);
   logic [2:0]          addr;
   logic                wr_strobe;
   logic                rd_strobe;
   logic [BusWidth-1:0] data_in;
   logic [BusWidth-1:0] data_out;

   modport master (output addr, wr_strobe, rd_strobe, data_in, input data_out);
   modport slave  (input addr, wr_strobe, rd_strobe, data_in, output data_out);
endinterface

// File: rtl/db25_input_filter.sv
// Input conditioner for the two DB25 ports: 2-FF sync, per-pin glitch filter,
// sticky per-pin edge latches and a small register window on the hostmot2 bus.
module db25_input_filter #(
   parameter int PortWidth   = 17,
   parameter int IOWidth     = 2 * PortWidth,
   parameter int FilterBits  = 4,
   parameter int FilterReset = 3,
   parameter int BusWidth    = 32
) (
   input  logic                clklow,
   input  logic                reset,
   input  logic [IOWidth-1:0]  gpio_in,
   db25_input_filter_if.slave  bus,
   output logic [IOWidth-1:0]  io_filt,
   output logic                edge_irq
);

   localparam int HiBits = IOWidth - BusWidth;

   typedef enum logic [2:0] {
      ADDR_FILT_LO = 3'd0,
      ADDR_FILT_HI = 3'd1,
      ADDR_EDGE_LO = 3'd2,
      ADDR_EDGE_HI = 3'd3,
      ADDR_LEN     = 3'd4
   } reg_addr_e;

   logic [IOWidth-1:0]    r_s1;
   logic [IOWidth-1:0]    r_s2;
   logic [IOWidth-1:0]    r_filt;
   logic [IOWidth-1:0]    r_latch;
   logic [FilterBits-1:0] r_cnt [IOWidth];
   logic [FilterBits-1:0] r_len;
   logic                  r_irq;
   logic [BusWidth-1:0]   r_dout;

   reg_addr_e             w_addr;
   logic [IOWidth-1:0]    w_toggle;
   logic [IOWidth-1:0]    w_clr;
   logic [FilterBits-1:0] w_cnt_next [IOWidth];
   logic [BusWidth-1:0]   w_rd_data;

   assign w_addr = reg_addr_e'(bus.addr);

   // A pin toggles once s2 has disagreed with filt for L+1 consecutive samples.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_toggle   = '0;
      w_cnt_next = '{default: '0};
      for (int i = 0; i < IOWidth; i++) begin
         if (r_s2[i] != r_filt[i]) begin
            if (r_cnt[i] >= r_len) w_toggle[i] = 1'b1;
            else                   w_cnt_next[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (bus.wr_strobe && w_addr == ADDR_EDGE_LO) w_clr[BusWidth-1:0]       = bus.data_in;
      if (bus.wr_strobe && w_addr == ADDR_EDGE_HI) w_clr[IOWidth-1:BusWidth] = bus.data_in[HiBits-1:0];
   end

   always_comb begin
      w_rd_data = '0;
      case (w_addr)
         ADDR_FILT_LO: w_rd_data                   = r_filt[BusWidth-1:0];
         ADDR_FILT_HI: w_rd_data[HiBits-1:0]       = r_filt[IOWidth-1:BusWidth];
         ADDR_EDGE_LO: w_rd_data                   = r_latch[BusWidth-1:0];
         ADDR_EDGE_HI: w_rd_data[HiBits-1:0]       = r_latch[IOWidth-1:BusWidth];
         ADDR_LEN:     w_rd_data[FilterBits-1:0]   = r_len;
         default:      w_rd_data                   = '0;
      endcase
   end

   // NOTE: state uses <= so every register samples the values from before this edge.
   always_ff @(posedge clklow) begin
      if (reset) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_filt  <= '0;
         r_latch <= '0;
         // NOTE: the counters are discrete flops, not a RAM, so clearing them all on reset is cheap.
         r_cnt   <= '{default: '0};
         r_len   <= FilterBits'(FilterReset);
         r_irq   <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_s1    <= gpio_in;
         r_s2    <= r_s1;
         r_filt  <= r_filt ^ w_toggle;
         r_cnt   <= w_cnt_next;
         // A new edge on the clearing cycle keeps its latch bit.
         r_latch <= (r_latch & ~w_clr) | w_toggle;
         r_irq   <= |r_latch;
         if (bus.rd_strobe) r_dout <= w_rd_data;
         if (bus.wr_strobe && w_addr == ADDR_LEN) r_len <= bus.data_in[FilterBits-1:0];
      end
   end

   assign io_filt      = r_filt;
   assign edge_irq     = r_irq;
   assign bus.data_out = r_dout;

endmodule

// File: tb/tb_db25_input_filter.sv
// Bench for db25_input_filter: directed sequences, a register table and a
// randomized run compared against a streak-counting reference model.
module tb_db25_input_filter;

   localparam int IOW = 34;

   logic           clklow = 1'b0;
   logic           reset;
   logic [IOW-1:0] gpio_in;
   logic [IOW-1:0] io_filt;
   logic           edge_irq;

   db25_input_filter_if bus ();

   db25_input_filter dut (
      .clklow   (clklow),
      .reset    (reset),
      .gpio_in  (gpio_in),
      .bus      (bus),
      .io_filt  (io_filt),
      .edge_irq (edge_irq)
   );

   always #10 clklow = ~clklow;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // A pin's filtered value changes once the synchronized input has disagreed
   // with it on L+1 consecutive clocks; any agreement resets the streak.
   logic [IOW-1:0] m_s1, m_s2, m_filt, m_latch, m_acc, m_clr;
   int             m_run [IOW];
   int             m_len;
   logic           m_irq;
   logic [31:0]    m_dout;

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_filt[31:0];
         3'd1:    return {30'd0, m_filt[33:32]};
         3'd2:    return m_latch[31:0];
         3'd3:    return {30'd0, m_latch[33:32]};
         3'd4:    return 32'(m_len);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clklow) begin
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_filt = '0; m_latch = '0;
         for (int i = 0; i < IOW; i++) m_run[i] = 0;
         m_len = 3; m_irq = 1'b0; m_dout = '0;
      end else begin
         m_acc = '0;
         for (int i = 0; i < IOW; i++) begin
            if (m_s2[i] == m_filt[i]) m_run[i] = 0;
            else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] > m_len) begin
                  m_acc[i] = 1'b1;
                  m_run[i] = 0;
               end
            end
         end
         if (bus.rd_strobe) m_dout = m_read(bus.addr);
         m_irq = |m_latch;
         m_clr = '0;
         if (bus.wr_strobe && bus.addr == 3'd2) m_clr[31:0]  = bus.data_in;
         if (bus.wr_strobe && bus.addr == 3'd3) m_clr[33:32] = bus.data_in[1:0];
         m_latch = (m_latch & ~m_clr) | m_acc;
         m_filt  = m_filt ^ m_acc;
         if (bus.wr_strobe && bus.addr == 3'd4) m_len = int'(bus.data_in[3:0]);
         m_s2 = m_s1;
         m_s1 = gpio_in;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clklow);
         @(negedge clklow);
      end
   endtask

   task automatic bus_op(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
      bus.addr      = a;
      bus.rd_strobe = rd;
      bus.wr_strobe = wr;
      bus.data_in   = d;
      tick();
      bus.rd_strobe = 1'b0;
      bus.wr_strobe = 1'b0;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      bus_op(1'b0, 1'b1, a, d);
   endtask

   task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
      bus_op(1'b1, 1'b0, a, 32'd0);
      check(name, bus.data_out, exp);
   endtask

   task automatic do_reset();
      gpio_in = '0;
      reset   = 1'b1;
      tick(2);
      reset   = 1'b0;
   endtask

   // Drive pin 20 high for n cycles and watch io_filt[20] over a fixed window.
   task automatic pulse_test(input int n, input int exp_hi, input int exp_rises, input logic [31:0] exp_latch);
      int   hi = 0;
      int   rises = 0;
      logic prev = 1'b0;
      do_reset();
      for (int c = 0; c < 16; c++) begin
         gpio_in[20] = (c < n);
         tick();
         if (io_filt[20]) hi++;
         if (io_filt[20] && !prev) rises++;
         prev = io_filt[20];
      end
      check($sformatf("pulse%0d high cycles", n), 64'(hi), 64'(exp_hi));
      check($sformatf("pulse%0d rises", n), 64'(rises), 64'(exp_rises));
      rd_check($sformatf("pulse%0d latch", n), 3'd2, exp_latch);
   endtask

   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [$];
      int   r;

      reset = 1'b1; gpio_in = '0;
      bus.addr = '0; bus.rd_strobe = 1'b0; bus.wr_strobe = 1'b0; bus.data_in = '0;
      @(negedge clklow);

      // Reset state.
      do_reset();
      check("reset io_filt", io_filt, 0);
      check("reset edge_irq", edge_irq, 0);
      check("reset data_out", bus.data_out, 0);
      rd_check("reset L", 3'd4, 32'd3);
      rd_check("reset filt lo", 3'd0, 32'd0);

      // L=3 step on pin 5: visible after E5, irq after E6.
      gpio_in[5] = 1'b1;
      tick(5);
      check("step E4 io_filt[5]", io_filt[5], 0);
      tick();
      check("step E5 io_filt[5]", io_filt[5], 1);
      check("step E5 edge_irq", edge_irq, 0);
      tick();
      check("step E6 edge_irq", edge_irq, 1);
      rd_check("step latch", 3'd2, 32'h0000_0020);

      // Pulse widths around L+1 on pin 20.
      pulse_test(3, 0, 0, 32'd0);
      pulse_test(4, 4, 1, 32'h0010_0000);

      // L=0: pin 33 follows after three edges.
      do_reset();
      wr_reg(3'd4, 32'd0);
      gpio_in[33] = 1'b1;
      tick(2);
      check("L0 rise E1", io_filt[33], 0);
      tick();
      check("L0 rise E2", io_filt[33], 1);
      rd_check("L0 filt hi", 3'd1, 32'h2);
      gpio_in[33] = 1'b0;
      tick(2);
      check("L0 fall E1", io_filt[33], 1);
      tick();
      check("L0 fall E2", io_filt[33], 0);

      // W1C, read-during-clear and set-wins.
      do_reset();
      wr_reg(3'd4, 32'd0);
      gpio_in[0] = 1'b1; gpio_in[17] = 1'b1;
      tick(4);
      rd_check("w1c before", 3'd2, 32'h0002_0001);
      bus_op(1'b1, 1'b1, 3'd2, 32'h1);
      check("w1c read pre-clear", bus.data_out, 32'h0002_0001);
      rd_check("w1c after", 3'd2, 32'h0002_0000);
      check("w1c edge_irq", edge_irq, 1);
      gpio_in[0] = 1'b0;
      tick(2);
      wr_reg(3'd2, 32'h1);
      check("set-wins io_filt[0]", io_filt[0], 0);
      rd_check("set-wins latch", 3'd2, 32'h0002_0001);

      // Shrinking L while a count is in flight, then reset mid-count.
      do_reset();
      wr_reg(3'd4, 32'd5);
      gpio_in[8] = 1'b1;
      tick(4);
      wr_reg(3'd4, 32'd1);
      check("shrink L write edge", io_filt[8], 0);
      tick();
      check("shrink L next edge", io_filt[8], 1);
      rd_check("shrink filt lo", 3'd0, 32'h0000_0100);
      gpio_in[9] = 1'b1;
      tick(3);
      reset = 1'b1;
      tick();
      check("midreset io_filt", io_filt, 0);
      check("midreset edge_irq", edge_irq, 0);
      check("midreset data_out", bus.data_out, 0);
      gpio_in = '0;
      reset = 1'b0;
      rd_check("midreset L", 3'd4, 32'd3);

      // Register map table, with a settled input pattern.
      do_reset();
      wr_reg(3'd4, 32'd0);
      gpio_in = 34'h2_8000_0081;
      tick(4);
      tbl.push_back('{1'b0, 3'd2, 32'h0,        32'h8000_0081});
      tbl.push_back('{1'b0, 3'd3, 32'h0,        32'h0000_0002});
      tbl.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b1, 3'd4, 32'h7,        32'h7});
      tbl.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0});
      tbl.push_back('{1'b1, 3'd0, 32'h0,        32'h8000_0081});
      tbl.push_back('{1'b1, 3'd1, 32'h0,        32'h0000_0002});
      tbl.push_back('{1'b0, 3'd2, 32'h0,        32'h0});
      tbl.push_back('{1'b0, 3'd3, 32'h0,        32'h0});
      tbl.push_back('{1'b0, 3'd4, 32'h0,        32'h7});
      foreach (tbl[k]) begin
         if (tbl[k].wr) wr_reg(tbl[k].addr, tbl[k].wdata);
         rd_check($sformatf("table[%0d] addr %0d", k, tbl[k].addr), tbl[k].addr, tbl[k].exp);
      end
      check("table edge_irq", edge_irq, 0);

      // Randomized run against the model.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < IOW; b++)
            if ($urandom_range(0, 5) == 0) gpio_in[b] = ~gpio_in[b];
         r             = int'($urandom_range(0, 99));
         bus.rd_strobe = 1'($urandom_range(0, 1));
         bus.addr      = 3'($urandom_range(0, 7));
         bus.wr_strobe = 1'b0;
         bus.data_in   = $urandom;
         if (r < 3) begin
            bus.wr_strobe = 1'b1;
            bus.addr      = 3'd4;
            bus.data_in   = $urandom_range(0, 4);
         end else if (r < 15) begin
            bus.wr_strobe = 1'b1;
            bus.addr      = 3'($urandom_range(2, 3));
         end
         reset = ($urandom_range(0, 299) == 0);
         tick();
         check("rand io_filt", io_filt, m_filt);
         check("rand edge_irq", edge_irq, m_irq);
         check("rand data_out", bus.data_out, m_dout);
      end
      bus.rd_strobe = 1'b0;
      bus.wr_strobe = 1'b0;
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
